// File: rtl/fetch_pkg.sv
// fetch_pkg: shared widths, reset fetch address and FSM state type for instr_fetch
package fetch_pkg;
   localparam int ADDR_W_DEF = 8;
   localparam int DATA_W_DEF = 16;
   localparam logic [7:0] RESET_ADDR = 8'h80;
   typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: DEPTH-entry instruction buffer.
//   push/din    write an entry (ignored when full)
//   pop         drop the head entry (ignored when empty)
//   clear       empty the buffer, overriding push and pop
//   dout        head entry; full/empty/count report occupancy
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int W     = 24
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  logic                   pop,
   input  logic                   clear,
   input  logic [W-1:0]           din,
   output logic [W-1:0]           dout,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);
   localparam int PW = $clog2(DEPTH);
   logic [W-1:0]  mem [DEPTH];
   logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
   logic [PW:0]   cnt_q, cnt_d;
   logic          do_push, do_pop;
   always_comb begin
      do_push = push && !full && !clear;
      do_pop  = pop && !empty && !clear;
      wr_d    = clear ? '0 : wr_q + PW'(do_push);
      rd_d    = clear ? '0 : rd_q + PW'(do_pop);
      cnt_d   = clear ? '0 : cnt_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
      end
   end
   // storage is deliberately left out of reset; only pointers and count matter
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_q] <= din;
   end
   assign dout  = mem[rd_q];
   assign full  = cnt_q == (PW+1)'(DEPTH);
   assign empty = cnt_q == '0;
   assign count = cnt_q;
endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: fetches one instruction per accepted PC into a small buffer.
//   pc_*   fetch requests from the program counter (pc_ready gates acceptance)
//   mem_*  single outstanding read to instruction memory, held until mem_ack
//   ir_*   oldest buffered instruction and its address, consumed by ir_ready
//   flush  empties the buffer and discards any in-flight read
module instr_fetch
   import fetch_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF,
   parameter int DEPTH  = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] pc_addr,
   input  logic              pc_valid,
   output logic              pc_ready,
   input  logic              flush,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_ack,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [DATA_W-1:0] ir,
   output logic [ADDR_W-1:0] ir_addr,
   output logic              ir_valid,
   input  logic              ir_ready
);
   state_t                    state_q, state_d;
   logic [ADDR_W-1:0]         mem_addr_q, mem_addr_d;
   logic                      push, full, empty;
   logic [ADDR_W+DATA_W-1:0]  head;
   logic [$clog2(DEPTH):0]    count;
   always_comb begin
      state_d    = state_q;
      mem_addr_d = mem_addr_q;
      push       = 1'b0;
      pc_ready   = state_q == IDLE && !full && !flush;
      case (state_q)
         IDLE:    if (pc_valid && pc_ready) begin
                     mem_addr_d = pc_addr;
                     state_d    = REQ;
                  end
         // an ack coinciding with flush completes the read but drops its data
         REQ:     if (mem_ack) begin
                     push    = !flush;
                     state_d = IDLE;
                  end else if (flush) begin
                     state_d = DRAIN;
                  end
         DRAIN:   if (mem_ack) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         mem_addr_q <= ADDR_W'(RESET_ADDR);
      end else begin
         state_q    <= state_d;
         mem_addr_q <= mem_addr_d;
      end
   end
   fetch_fifo #(.DEPTH(DEPTH), .W(ADDR_W + DATA_W)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (ir_valid && ir_ready),
      .clear (flush),
      .din   ({mem_addr_q, mem_rdata}),
      .dout  (head),
      .full  (full),
      .empty (empty),
      .count (count)
   );
   assign mem_req  = state_q != IDLE;
   assign mem_addr = mem_addr_q;
   assign ir_valid = count != '0;
   // storage is not reset, so mask the head while the buffer is empty
   assign ir       = empty ? '0 : head[DATA_W-1:0];
   assign ir_addr  = empty ? '0 : head[ADDR_W+DATA_W-1 -: ADDR_W];
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: scoreboard bench for instr_fetch with directed and random traffic
module tb_instr_fetch;
   localparam int DEPTH = 2;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [7:0]  pc_addr = '0;
   logic        pc_valid = 1'b0;
   logic        pc_ready;
   logic        flush = 1'b0;
   logic        mem_req;
   logic [7:0]  mem_addr;
   logic        mem_ack = 1'b0;
   logic [15:0] mem_rdata = '0;
   logic [15:0] ir;
   logic [7:0]  ir_addr;
   logic        ir_valid;
   logic        ir_ready = 1'b0;

   int checks = 0;
   int errors = 0;
   logic [23:0] exp_q[$];
   logic [23:0] exp_new;
   logic        exp_new_v = 1'b0;
   int          m_state = 0;
   logic [7:0]  m_addr = 8'h80;
   logic        er;

   instr_fetch #(.ADDR_W(8), .DATA_W(16), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .pc_addr(pc_addr), .pc_valid(pc_valid), .pc_ready(pc_ready),
      .flush(flush), .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
      .mem_rdata(mem_rdata), .ir(ir), .ir_addr(ir_addr), .ir_valid(ir_valid), .ir_ready(ir_ready)
   );

   always #5 clk = ~clk;

   task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s actual %0h required %0h at %0t", n, a, e, $time);
      end
   endtask

   // one cycle of stimulus; a read acked while live and not flushed is expected output
   task automatic cyc(input logic pv, input logic [7:0] pa, input logic ack,
                      input logic [15:0] d, input logic ird, input logic fl);
      @(posedge clk);
      #1;
      pc_valid  = pv;
      pc_addr   = pa;
      mem_ack   = ack;
      mem_rdata = d;
      ir_ready  = ird;
      flush     = fl;
      if (m_state == 1 && ack && !fl) begin
         exp_new   = {m_addr, d};
         exp_new_v = 1'b1;
      end
   endtask

   // monitor: compares DUT against the model, then advances the model one cycle
   always @(negedge clk) begin
      if (!rst) begin
         chk("rst_mem_req", mem_req, 0);
         chk("rst_mem_addr", mem_addr, 8'h80);
         chk("rst_ir_valid", ir_valid, 0);
         chk("rst_ir", ir, 0);
         chk("rst_ir_addr", ir_addr, 0);
         exp_q.delete();
         exp_new_v = 1'b0;
         m_state   = 0;
      end else begin
         er = m_state == 0 && exp_q.size() < DEPTH && !flush;
         chk("pc_ready", pc_ready, er);
         chk("mem_req", mem_req, m_state != 0);
         if (m_state != 0) chk("mem_addr", mem_addr, m_addr);
         chk("ir_valid", ir_valid, exp_q.size() != 0);
         if (exp_q.size() != 0) begin
            chk("ir", ir, exp_q[0][15:0]);
            chk("ir_addr", ir_addr, exp_q[0][23:16]);
         end
         if (flush) exp_q.delete();
         else if (exp_q.size() != 0 && ir_ready) void'(exp_q.pop_front());
         if (exp_new_v) exp_q.push_back(exp_new);
         exp_new_v = 1'b0;
         if (m_state == 0) begin
            if (pc_valid && er) begin
               m_state = 1;
               m_addr  = pc_addr;
            end
         end else if (m_state == 1) begin
            m_state = mem_ack ? 0 : flush ? 2 : 1;
         end else if (mem_ack) begin
            m_state = 0;
         end
      end
   end

   initial begin
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      // single fetch, 2-cycle latency
      cyc(1, 8'h80, 0, 16'h0, 1, 0);
      cyc(0, 8'h00, 1, 16'hA5A5, 1, 0);
      cyc(0, 8'h00, 0, 16'h0, 1, 0);
      // backpressure fills the buffer, then drains in order
      cyc(1, 8'h80, 0, 16'h0, 0, 0);
      cyc(0, 8'h00, 1, 16'h1111, 0, 0);
      cyc(1, 8'h81, 0, 16'h0, 0, 0);
      cyc(0, 8'h00, 1, 16'h2222, 0, 0);
      cyc(1, 8'h82, 0, 16'h0, 0, 0);
      cyc(0, 8'h00, 0, 16'h0, 1, 0);
      cyc(0, 8'h00, 0, 16'h0, 0, 0);
      cyc(0, 8'h00, 0, 16'h0, 1, 0);
      // wait states
      cyc(1, 8'h44, 0, 16'h0, 1, 0);
      repeat (3) cyc(0, 8'h00, 0, 16'h0, 1, 0);
      cyc(0, 8'h00, 1, 16'h3333, 1, 0);
      repeat (2) cyc(0, 8'h00, 0, 16'h0, 1, 0);
      // flush in REQ with one entry buffered; drained data is dropped
      cyc(1, 8'h50, 0, 16'h0, 0, 0);
      cyc(0, 8'h00, 1, 16'h5555, 0, 0);
      cyc(1, 8'h51, 0, 16'h0, 0, 0);
      cyc(0, 8'h00, 0, 16'h0, 0, 1);
      cyc(0, 8'h00, 0, 16'h0, 0, 0);
      cyc(0, 8'h00, 1, 16'h1234, 0, 0);
      cyc(0, 8'h00, 0, 16'h0, 0, 0);
      // simultaneous push and pop at count 1
      cyc(1, 8'h60, 0, 16'h0, 0, 0);
      cyc(0, 8'h00, 1, 16'h6666, 0, 0);
      cyc(1, 8'h61, 0, 16'h0, 0, 0);
      cyc(0, 8'h00, 1, 16'h7777, 1, 0);
      cyc(0, 8'h00, 0, 16'h0, 0, 0);
      cyc(0, 8'h00, 0, 16'h0, 1, 0);
      // reset mid-REQ with an entry buffered; a later ack must be ignored
      cyc(1, 8'h20, 0, 16'h0, 0, 0);
      cyc(0, 8'h00, 1, 16'hBEEF, 0, 0);
      cyc(1, 8'h30, 0, 16'h0, 0, 0);
      cyc(0, 8'h00, 0, 16'h0, 0, 0);
      @(posedge clk);
      #1;
      pc_valid = 1'b0;
      ir_ready = 1'b0;
      #1 rst = 1'b0;
      #1;
      chk("async_mem_req", mem_req, 0);
      chk("async_mem_addr", mem_addr, 8'h80);
      chk("async_ir_valid", ir_valid, 0);
      @(posedge clk);
      #1 rst = 1'b1;
      cyc(0, 8'h00, 1, 16'hDEAD, 1, 0);
      cyc(0, 8'h00, 0, 16'h0, 1, 0);
      // randomized traffic, including stray acks and flushes
      for (int i = 0; i < 3000; i++)
         cyc($urandom_range(1, 0) == 1, 8'($urandom), $urandom_range(2, 0) == 0,
             16'($urandom), $urandom_range(3, 0) != 0, $urandom_range(15, 0) == 0);
      cyc(0, 8'h00, 0, 16'h0, 1, 0);
      @(negedge clk);
      #1 $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
